// File: rtl/dma_disk_responder.sv
// dma_disk_responder
//   Target-side model of the disk endpoint driven by the DMA controller.
//   It serves one-word read/write requests from a DEPTH-word store. A
//   non-sequential access pays SEEK_LAT extra cycles of seek time. An access
//   to last_addr+1 streams without a seek penalty.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high; aborts any request in flight
//   en_w     : write request (DMA -> disk), level-sampled while idle
//   en_r     : read request (disk -> DMA), level-sampled while idle
//   address  : word address of the request
//   DataIn   : write data, captured with the request
//   DataOut  : read data, held from the done cycle until the next read completes
//   busy     : a request is in progress and new requests are ignored
//   done     : one-cycle completion pulse
//   error    : one-cycle fault pulse, coincident with done
//
// Handshake: a request is taken at any rising edge where the FSM is IDLE and
// en_w|en_r is high. busy rises on the following cycle and stays high until
// the completion edge. On that edge done pulses for one cycle and busy drops.
// The done cycle is itself IDLE, so a request held through it is accepted
// at its closing edge. en_w/en_r are ignored while busy.
//
// The FSM state is the 'state' signal. It has a named enum type so that
// checkers can bind to it hierarchically.

module dma_disk_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 65,
  parameter int DEPTH    = 256,
  parameter int SEEK_LAT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_w,
  input  logic              en_r,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter only ever holds SEEK_LAT-1 down to 0.
  localparam int CNT_W     = (SEEK_LAT > 1) ? $clog2(SEEK_LAT) : 1;
  localparam int SEEK_INIT = (SEEK_LAT > 0) ? SEEK_LAT - 1 : 0;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    ACCESS = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_write;
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
  logic [CNT_W-1:0]  seek_cnt;
  logic [IDX_W-1:0]  req_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Faulted requests never reach ACCESS, so req_addr is in range here.
  assign req_idx = req_addr[IDX_W-1:0];

  // The store is never cleared. A reset on the write edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && req_write) begin
      mem[req_idx] <= req_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      DataOut    <= '0;
      last_valid <= 1'b0;
      last_addr  <= '0;
      seek_cnt   <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_write  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (en_w | en_r) begin
            req_addr  <= address;
            req_data  <= DataIn;
            req_write <= en_w;
            busy      <= 1'b1;
            if ((en_w & en_r) || (address >= DEPTH_A)) begin
              state <= FAULT;
            end else if (last_valid && (address == last_addr + ADDR_W'(1))) begin
              // The head is already positioned on the next word.
              state <= ACCESS;
            end else if (SEEK_LAT == 0) begin
              state <= ACCESS;
            end else begin
              // The counter runs from SEEK_LAT-1 to 0, which gives SEEK_LAT cycles in SEEK.
              state    <= SEEK;
              seek_cnt <= CNT_W'(SEEK_INIT);
            end
          end
        end
        SEEK: begin
          if (seek_cnt == '0) begin
            state <= ACCESS;
          end else begin
            seek_cnt <= seek_cnt - CNT_W'(1);
          end
        end
        ACCESS: begin
          if (!req_write) begin
            DataOut <= mem[req_idx];
          end
          last_addr  <= req_addr;
          last_valid <= 1'b1;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        FAULT: begin
          // Memory, DataOut and the sequential-access tracking are left as they are.
          done  <= 1'b1;
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
